// File: rtl/frame_writer_pkg.sv
// Shared geometry, bus widths and FSM encoding for the frame writer.
// Screen size here is the default; the top can be re-parameterised.
package frame_writer_pkg;
  localparam int SCR_W      = 160;
  localparam int SCR_H      = 120;
  localparam int SCR_PIXELS = SCR_W * SCR_H;
  localparam int ADDR_W     = 15;
  localparam int COLOUR_W   = 3;
  localparam int XY_W       = 10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fw_state_t;
endpackage

// File: rtl/frame_writer_xy_to_addr.sv
// Combinational range check and linear address y*SCR_W+x in 15-bit unsigned math.
module xy_to_addr #(
  parameter int SCR_W = frame_writer_pkg::SCR_W,
  parameter int SCR_H = frame_writer_pkg::SCR_H
) (
  input  logic [frame_writer_pkg::XY_W-1:0]   x,
  input  logic [frame_writer_pkg::XY_W-1:0]   y,
  output logic                                in_range,
  output logic [frame_writer_pkg::ADDR_W-1:0] addr
);
  import frame_writer_pkg::*;

  localparam logic [XY_W-1:0]   W_XY   = XY_W'(SCR_W);
  localparam logic [XY_W-1:0]   H_XY   = XY_W'(SCR_H);
  localparam logic [ADDR_W-1:0] W_ADDR = ADDR_W'(SCR_W);

  always_comb begin
    in_range = (x < W_XY) && (y < H_XY);
    addr     = (ADDR_W'(y) * W_ADDR) + ADDR_W'(x);
  end
endmodule

// File: rtl/frame_writer.sv
// Frame-RAM write-port driver: single-cycle pixel plots and a full-screen clear fill.
// All outputs registered; plots land one cycle after acceptance, clear streams one pixel per cycle.
module frame_writer #(
  parameter int SCR_W = frame_writer_pkg::SCR_W,
  parameter int SCR_H = frame_writer_pkg::SCR_H
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  plot,
  input  logic [frame_writer_pkg::XY_W-1:0]     x,
  input  logic [frame_writer_pkg::XY_W-1:0]     y,
  input  logic [frame_writer_pkg::COLOUR_W-1:0] colour,
  input  logic                                  clear,
  input  logic [frame_writer_pkg::COLOUR_W-1:0] clear_colour,
  output logic                                  ready,
  output logic                                  wr_en,
  output logic [frame_writer_pkg::ADDR_W-1:0]   wr_addr,
  output logic [frame_writer_pkg::COLOUR_W-1:0] wr_data,
  output logic                                  clear_done,
  output logic [7:0]                            oor_count
);
  import frame_writer_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCR_W * SCR_H - 1);

  fw_state_t             state_q, state_d;
  logic                  ready_d, wr_en_d, clear_done_d;
  logic [ADDR_W-1:0]     wr_addr_d;
  logic [COLOUR_W-1:0]   wr_data_d;
  logic [7:0]            oor_d;
  logic                  pix_in_range;
  logic [ADDR_W-1:0]     pix_addr;

  xy_to_addr #(
    .SCR_W (SCR_W),
    .SCR_H (SCR_H)
  ) u_xy_to_addr (
    .x        (x),
    .y        (y),
    .in_range (pix_in_range),
    .addr     (pix_addr)
  );

  // During a fill, wr_addr doubles as the fill counter and wr_data holds the latched fill colour.
  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr;
    wr_data_d    = wr_data;
    clear_done_d = 1'b0;
    oor_d        = oor_count;

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d   = ST_CLEAR;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = clear_colour;
        end else if (plot) begin
          if (pix_in_range) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pix_addr;
            wr_data_d = colour;
          end else if (oor_count != 8'hFF) begin
            oor_d = oor_count + 8'd1;
          end
        end
      end
      ST_CLEAR: begin
        if (wr_addr == LAST_ADDR) begin
          state_d      = ST_IDLE;
          clear_done_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      ready      <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      clear_done <= 1'b0;
      oor_count  <= '0;
    end else begin
      state_q    <= state_d;
      ready      <= ready_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      clear_done <= clear_done_d;
      oor_count  <= oor_d;
    end
  end
endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 Parameter SCR_W, default 160, screen width in pixels.
REQ-002 Parameter SCR_H, default 120, screen height in pixels.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 plot  input  1  pixel-valid strobe from a drawing engine.
REQ-006 x  input  10  pixel column.
REQ-007 y  input  10  pixel row.
REQ-008 colour  input  3  pixel colour.
REQ-009 clear  input  1  request to fill the whole buffer.
REQ-010 clear_colour  input  3  fill colour, sampled with clear.
REQ-011 ready  output  1  high when a plot is accepted this cycle.
REQ-012 wr_en  output  1  frame-RAM write enable.
REQ-013 wr_addr  output  15  frame-RAM address, y*SCR_W+x.
REQ-014 wr_data  output  3  frame-RAM write colour.
REQ-015 clear_done  output  1  one-cycle pulse after the last clear write.
REQ-016 oor_count  output  8  saturating count of rejected out-of-range plots.

Function
REQ-017 FSM states IDLE and CLEAR; reset state IDLE.
REQ-018 ready SHALL be 1 in IDLE and 0 in CLEAR, registered (no combinational path from inputs).
REQ-019 IDLE, plot=1, clear=0, x<SCR_W, y<SCR_H: next cycle wr_en=1, wr_addr=y*SCR_W+x, wr_data=colour (latency 1).
REQ-020 Back-to-back plots SHALL be accepted every cycle, one write per plot, order preserved.
REQ-021 IDLE, plot=1, x>=SCR_W or y>=SCR_H: no write; oor_count increments, holding at 255.
REQ-022 IDLE, clear=1: latch clear_colour, enter CLEAR; same-cycle plot is dropped, not written, not counted.
REQ-023 CLEAR: wr_en=1 each cycle, wr_addr 0,1,...,SCR_W*SCR_H-1 (19199), wr_data=latched colour.
REQ-024 Cycle after address 19199 written: state IDLE, clear_done=1 for exactly one cycle, ready=1.
REQ-025 Clear takes exactly 19200 write cycles; clear and plot inputs ignored during CLEAR.
REQ-026 Address arithmetic SHALL be 15-bit unsigned; in-range max 19199, no wrap.
REQ-027 wr_en=0 in every cycle not covered by REQ-019 or REQ-023.

Reset
REQ-028 resetn=0 at a clock edge: next cycle state=IDLE, ready=1, wr_en=0, wr_addr=0, wr_data=0, clear_done=0, oor_count=0.
REQ-029 Reset mid-CLEAR SHALL abort the fill immediately, no further writes, no clear_done pulse.
REQ-030 Reset SHALL override simultaneous plot or clear.

Structure
REQ-031 Shared package holds SCR_W, SCR_H, SCR_PIXELS=19200, ADDR_W=15, COLOUR_W=3 and the FSM state encoding.
REQ-032 Sub-module xy_to_addr (combinational range check and y*SCR_W+x) is instantiated once.
REQ-033 Frame RAM is external; this block drives only its write port.

Verification
REQ-034 Plot x=5, y=2, colour=3'b101 -> one cycle later wr_en=1, wr_addr=325, wr_data=5, single pulse.
REQ-035 Plot x=159,y=119 then x=160,y=0 then x=0,y=120 on consecutive cycles -> one write to 19199; oor_count=2.
REQ-036 Clear with clear_colour=3'b010 -> 19200 consecutive writes 0..19199 data 2, ready=0 throughout, clear_done high on cycle 19201 only.
REQ-037 clear=1 and plot=1 same cycle in IDLE -> plot not written, oor_count unchanged, fill proceeds.
REQ-038 resetn=0 at fill address 1000 -> wr_en=0 next cycle, ready=1, no clear_done ever.
REQ-039 300 out-of-range plots -> oor_count saturates at 255.
